// File: rtl/multi_traffic_control.sv
// rtl/multi_traffic_control.sv - multi-road traffic light controller (GREEN/YELLOW/ALL_RED round robin)
// Optional emergency preemption ports and behaviour enabled by defining EMERGENCY_PREEMPT_EN.
module multi_traffic_control #(
    parameter int NUM_ROADS    = 4,
    parameter int GREEN_MIN    = 10,
    parameter int GREEN_MAX    = 40,
    parameter int YELLOW_TIME  = 4,
    parameter int ALL_RED_TIME = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_ROADS-1:0]   sensor,
`ifdef EMERGENCY_PREEMPT_EN
    input  logic                   preempt,
    input  logic [2:0]             preempt_road,
`endif
    output logic [3*NUM_ROADS-1:0] lights,
    output logic [2:0]             active_road,
    output logic [1:0]             phase
);

    typedef enum logic [1:0] {
        ST_GREEN   = 2'd0,
        ST_YELLOW  = 2'd1,
        ST_ALL_RED = 2'd2
    } state_t;

    localparam int T_A   = (GREEN_MAX > YELLOW_TIME) ? GREEN_MAX : YELLOW_TIME;
    localparam int T_MAX = (T_A > ALL_RED_TIME) ? T_A : ALL_RED_TIME;
    localparam int TW    = $clog2(T_MAX + 1);

    localparam logic [TW-1:0] G_MIN_M1  = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] G_MAX_M1  = TW'(GREEN_MAX - 1);
    localparam logic [TW-1:0] Y_M1      = TW'(YELLOW_TIME - 1);
    localparam logic [TW-1:0] AR_M1     = TW'(ALL_RED_TIME - 1);

    state_t          state;
    logic [TW-1:0]   timer;
    logic [2:0]      next_road;
    logic [7:0]      sensor8;
    logic [7:0]      req;
    logic            pre_valid;
    logic [2:0]      pre_road;
    logic            green_done;

    assign sensor8 = 8'(sensor);
    assign phase   = state;

`ifdef EMERGENCY_PREEMPT_EN
    assign pre_valid = preempt && ({1'b0, preempt_road} < 4'(NUM_ROADS));
    assign pre_road  = preempt_road;
`else
    assign pre_valid = 1'b0;
    assign pre_road  = 3'd0;
`endif

    // Main road is always considered to be waiting when another road holds green.
    always_comb begin
        req = sensor8;
        req[active_road] = 1'b0;
        if (active_road != 3'd0)
            req[0] = 1'b1;
    end

    assign green_done = (req != 8'd0) &&
                        (((timer >= G_MIN_M1) && !sensor8[active_road]) || (timer == G_MAX_M1));

    function automatic logic [2:0] pick_next(input logic [7:0] r_req, input logic [2:0] r);
        logic [2:0] sel;
        logic [2:0] idx;
        logic       found;
        sel   = r;
        found = 1'b0;
        for (int k = 1; k <= NUM_ROADS; k++) begin
            idx = 3'((int'(r) + k) % NUM_ROADS);
            if (!found && r_req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [3*NUM_ROADS-1:0] lamp(input state_t ph, input logic [2:0] r);
        logic [3*NUM_ROADS-1:0] l;
        for (int i = 0; i < NUM_ROADS; i++) begin
            if (ph == ST_GREEN && r == 3'(i))
                l[3*i +: 3] = 3'b001;
            else if (ph == ST_YELLOW && r == 3'(i))
                l[3*i +: 3] = 3'b010;
            else
                l[3*i +: 3] = 3'b100;
        end
        return l;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_GREEN;
            timer       <= '0;
            active_road <= 3'd0;
            next_road   <= 3'd0;
            lights      <= lamp(ST_GREEN, 3'd0);
        end else begin
            case (state)
                ST_GREEN: begin
                    if (pre_valid && pre_road != active_road) begin
                        state     <= ST_YELLOW;
                        timer     <= '0;
                        next_road <= pre_road;
                        lights    <= lamp(ST_YELLOW, active_road);
                    end else if (!pre_valid && green_done) begin
                        state     <= ST_YELLOW;
                        timer     <= '0;
                        next_road <= pick_next(req, active_road);
                        lights    <= lamp(ST_YELLOW, active_road);
                    end else if (timer != G_MAX_M1) begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_YELLOW: begin
                    if (pre_valid)
                        next_road <= pre_road;
                    if (timer == Y_M1) begin
                        state  <= ST_ALL_RED;
                        timer  <= '0;
                        lights <= lamp(ST_ALL_RED, active_road);
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_ALL_RED: begin
                    if (timer == AR_M1) begin
                        state       <= ST_GREEN;
                        timer       <= '0;
                        active_road <= pre_valid ? pre_road : next_road;
                        next_road   <= pre_valid ? pre_road : next_road;
                        lights      <= lamp(ST_GREEN, pre_valid ? pre_road : next_road);
                    end else begin
                        if (pre_valid)
                            next_road <= pre_road;
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state       <= ST_GREEN;
                    timer       <= '0;
                    active_road <= 3'd0;
                    next_road   <= 3'd0;
                    lights      <= lamp(ST_GREEN, 3'd0);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_traffic_control.sv
// tb/tb_multi_traffic_control.sv - directed self-checking bench for multi_traffic_control
module tb_multi_traffic_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  sensor;
    logic [11:0] lights;
    logic [2:0]  active_road;
    logic [1:0]  phase;
`ifdef EMERGENCY_PREEMPT_EN
    logic        preempt;
    logic [2:0]  preempt_road;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [11:0] L_G0  = 12'b100_100_100_001;
    localparam logic [11:0] L_Y0  = 12'b100_100_100_010;
    localparam logic [11:0] L_AR  = 12'b100_100_100_100;
    localparam logic [11:0] L_G2  = 12'b100_001_100_100;
    localparam logic [11:0] L_Y1  = 12'b100_100_010_100;
    localparam logic [11:0] L_G3  = 12'b001_100_100_100;

    multi_traffic_control dut (
        .clk         (clk),
        .rst         (rst),
        .sensor      (sensor),
`ifdef EMERGENCY_PREEMPT_EN
        .preempt     (preempt),
        .preempt_road(preempt_road),
`endif
        .lights      (lights),
        .active_road (active_road),
        .phase       (phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] s);
        rst = 1'b1;
        sensor = s;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Number of cycles until phase or active_road changes; -1 if the bound expires.
    task automatic run_len(output int n);
        logic [1:0] p0;
        logic [2:0] a0;
        p0 = phase;
        a0 = active_road;
        n  = 0;
        do begin
            tick();
            n++;
        end while (phase == p0 && active_road == a0 && n < 200);
        if (n >= 200) n = -1;
    endtask

    int n;
    int bad;

    initial begin
`ifdef EMERGENCY_PREEMPT_EN
        preempt = 1'b0;
        preempt_road = 3'd0;
`endif
        // Reset state and idle hold
        do_reset(4'b0000);
        check("rst_lights", lights, L_G0);
        check("rst_phase", phase, 2'd0);
        check("rst_road", active_road, 3'd0);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (lights !== L_G0 || phase !== 2'd0) bad++;
        end
        check("idle_hold", bad, 0);
        // Timer saturated at GREEN_MAX-1: a new request exits immediately
        sensor = 4'b0010;
        tick();
        check("sat_exit_phase", phase, 2'd1);

        // Side road 2 demand from reset release
        do_reset(4'b0100);
        run_len(n); check("g0_len", n, 10);
        check("y0_lights", lights, L_Y0);
        check("y0_road", active_road, 3'd0);
        run_len(n); check("y0_len", n, 4);
        check("ar_lights", lights, L_AR);
        check("ar_phase", phase, 2'd2);
        run_len(n); check("ar_len", n, 2);
        check("g2_road", active_road, 3'd2);
        check("g2_lights", lights, L_G2);
        run_len(n); check("g2_len", n, 40);
        run_len(n); check("y2_len", n, 4);
        run_len(n); check("ar2_len", n, 2);
        check("back_g0_road", active_road, 3'd0);
        check("back_g0_phase", phase, 2'd0);

        // Road 1 green, sensor=1101 -> next is road 2
        do_reset(4'b0010);
        run_len(n); check("g0b_len", n, 10);
        sensor = 4'b1101;
        run_len(n); check("y0b_len", n, 4);
        run_len(n); check("arb_len", n, 2);
        check("g1_road", active_road, 3'd1);
        run_len(n); check("g1_len", n, 10);
        check("y1_lights", lights, L_Y1);
        run_len(n);
        run_len(n);
        check("scan_next", active_road, 3'd2);

        // Main road occupied, road 3 waiting -> GREEN_MAX
        do_reset(4'b1001);
        run_len(n); check("g0max_len", n, 40);
        run_len(n); check("y0c_len", n, 4);
        run_len(n); check("arc_len", n, 2);
        check("g3_road", active_road, 3'd3);
        check("g3_lights", lights, L_G3);

        // Reset during cycle 2 of road 2 yellow
        do_reset(4'b0100);
        run_len(n);
        run_len(n);
        run_len(n);
        run_len(n);
        check("pre_rst_road", active_road, 3'd2);
        check("pre_rst_phase", phase, 2'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_lights", lights, L_G0);
        check("mid_rst_phase", phase, 2'd0);
        check("mid_rst_road", active_road, 3'd0);

`ifdef EMERGENCY_PREEMPT_EN
        do_reset(4'b0000);
        tick(); tick(); tick();
        preempt = 1'b1;
        preempt_road = 3'd3;
        tick();
        check("pe_yellow", phase, 2'd1);
        run_len(n); check("pe_y_len", n, 4);
        run_len(n); check("pe_ar_len", n, 2);
        check("pe_road", active_road, 3'd3);
        sensor = 4'b0001;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (phase !== 2'd0 || active_road !== 3'd3) bad++;
        end
        check("pe_hold", bad, 0);
        preempt = 1'b0;
        tick();
        check("pe_release", phase, 2'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
